// File: rtl/dsp_axis_join_pipe.sv
// Three-stream AXI-Stream arithmetic join feeding a bubble-collapsing, stallable register pipeline.
// Optional TLAST agreement check enabled by defining DSP_AXIS_LAST_CHECK_EN.
module dsp_axis_join_pipe #(
    parameter int DATA_WIDTH  = 16,
    parameter int PIPE_STAGES = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_data_a,
    input  logic [DATA_WIDTH-1:0]   s_axis_data_b,
    input  logic [DATA_WIDTH-1:0]   s_axis_data_c,
    input  logic                    s_axis_valid_a,
    input  logic                    s_axis_valid_b,
    input  logic                    s_axis_valid_c,
    input  logic                    s_axis_last_a,
    input  logic                    s_axis_last_b,
    input  logic                    s_axis_last_c,
    output logic                    s_axis_ready_a,
    output logic                    s_axis_ready_b,
    output logic                    s_axis_ready_c,
    input  logic [1:0]              mode,
    output logic [2*DATA_WIDTH:0]   m_axis_data,
    output logic                    m_axis_valid,
    output logic                    m_axis_last,
    input  logic                    m_axis_ready,
    output logic                    err_last_mismatch
);

    localparam int RW = 2*DATA_WIDTH + 1;

    logic                   all_valid;
    logic                   can_accept;
    logic                   join_fire;
    logic                   join_last;
    logic signed [RW-1:0]   ea, eb, ec;
    logic signed [RW-1:0]   join_data;

    logic [PIPE_STAGES-1:0] stg_valid;
    logic [PIPE_STAGES-1:0] stg_last;
    logic [PIPE_STAGES-1:0] stg_ready;
    logic [RW-1:0]          stg_data [PIPE_STAGES];

    logic [PIPE_STAGES:0]   src_valid;
    logic [PIPE_STAGES:0]   src_last;
    logic [RW-1:0]          src_data [PIPE_STAGES+1];

    assign all_valid  = s_axis_valid_a & s_axis_valid_b & s_axis_valid_c;
    assign can_accept = stg_ready[0];
    assign join_fire  = all_valid & can_accept;
    assign join_last  = s_axis_last_a & s_axis_last_b & s_axis_last_c;

    assign s_axis_ready_a = join_fire;
    assign s_axis_ready_b = join_fire;
    assign s_axis_ready_c = join_fire;

    // Full-width signed arithmetic: result width covers every mode without overflow.
    always_comb begin
        ea = {{(RW-DATA_WIDTH){s_axis_data_a[DATA_WIDTH-1]}}, s_axis_data_a};
        eb = {{(RW-DATA_WIDTH){s_axis_data_b[DATA_WIDTH-1]}}, s_axis_data_b};
        ec = {{(RW-DATA_WIDTH){s_axis_data_c[DATA_WIDTH-1]}}, s_axis_data_c};
        join_data = '0;
        unique case (mode)
            2'd0: join_data = (ea + eb) * ec;
            2'd1: join_data = (ea - eb) * ec;
            2'd2: join_data = ea * eb + ec;
            2'd3: join_data = ea * eb - ec;
        endcase
    end

    // A stage may load when it, or any stage downstream of it, is empty, or the output drains.
    always_comb begin
        logic        acc;
        int unsigned idx;
        acc       = m_axis_ready;
        stg_ready = '0;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            idx            = PIPE_STAGES - 1 - i;
            acc            = acc | ~stg_valid[idx];
            stg_ready[idx] = acc;
        end
    end

    always_comb begin
        src_valid   = {stg_valid, join_fire};
        src_last    = {stg_last, join_last};
        src_data[0] = join_data;
        for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
            src_data[i+1] = stg_data[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stg_valid <= '0;
            stg_last  <= '0;
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                stg_data[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                if (stg_ready[i]) begin
                    stg_valid[i] <= src_valid[i];
                    stg_last[i]  <= src_valid[i] & src_last[i];
                    if (src_valid[i]) begin
                        stg_data[i] <= src_data[i];
                    end
                end
            end
        end
    end

    assign m_axis_valid = stg_valid[PIPE_STAGES-1];
    assign m_axis_last  = stg_last[PIPE_STAGES-1];
    assign m_axis_data  = stg_data[PIPE_STAGES-1];

`ifdef DSP_AXIS_LAST_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_last_mismatch <= 1'b0;
        end else if (join_fire &&
                     !(s_axis_last_a == s_axis_last_b && s_axis_last_b == s_axis_last_c)) begin
            err_last_mismatch <= 1'b1;
        end
    end
`else
    assign err_last_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_dsp_axis_join_pipe.sv
// Randomized and directed bench for dsp_axis_join_pipe against a queue-based reference model.
module tb_dsp_axis_join_pipe;

    localparam int DW = 16;
    localparam int S  = 2;
    localparam int W  = 2*DW + 1;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
        int           cyc;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] da, db, dc;
    logic          va, vb, vc;
    logic          la, lb, lc;
    logic          ra, rb, rc;
    logic [1:0]    mode;
    logic [W-1:0]  m_data;
    logic          m_valid, m_last, m_ready;
    logic          err;

    dsp_axis_join_pipe #(.DATA_WIDTH(DW), .PIPE_STAGES(S)) dut (
        .clk(clk), .reset(reset),
        .s_axis_data_a(da), .s_axis_data_b(db), .s_axis_data_c(dc),
        .s_axis_valid_a(va), .s_axis_valid_b(vb), .s_axis_valid_c(vc),
        .s_axis_last_a(la), .s_axis_last_b(lb), .s_axis_last_c(lc),
        .s_axis_ready_a(ra), .s_axis_ready_b(rb), .s_axis_ready_c(rc),
        .mode(mode),
        .m_axis_data(m_data), .m_axis_valid(m_valid), .m_axis_last(m_last),
        .m_axis_ready(m_ready),
        .err_last_mismatch(err)
    );

    always #5 clk = ~clk;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           cyc     = 0;
    int           npop    = 0;
    beat_t        sb[$];
    logic         fired;
    logic         lat_chk = 1'b0;
    logic         err_exp = 1'b0;
    logic         held    = 1'b0;
    logic [W-1:0] held_data;
    logic         held_last;
    logic [W-1:0] last_pop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] ref_calc(input logic signed [DW-1:0] a, b, c,
                                              input logic [1:0] m);
        longint sa = a;
        longint sbv = b;
        longint sc = c;
        longint x;
        case (m)
            2'd0:    x = (sa + sbv) * sc;
            2'd1:    x = (sa - sbv) * sc;
            2'd2:    x = sa * sbv + sc;
            default: x = sa * sbv - sc;
        endcase
        return x[W-1:0];
    endfunction

    // One clock: inputs were driven at the preceding negedge; sample, check, then advance.
    task automatic cycle();
        logic  all_v, exp_rdy, out_fire;
        beat_t e;
        #2;
        fired = 1'b0;
        if (!reset) begin
            all_v   = va & vb & vc;
            exp_rdy = all_v && ((sb.size() < S) || m_ready);
            check("ready_a", 64'(ra), 64'(exp_rdy));
            check("ready_bc", 64'({rb, rc}), 64'({exp_rdy, exp_rdy}));
            fired    = all_v && exp_rdy;
            out_fire = m_valid && m_ready;
            if (held) begin
                check("stall_hold", {30'b0, m_valid, m_last, m_data},
                      {30'b0, 1'b1, held_last, held_data});
            end
            held      = m_valid && !m_ready;
            held_data = m_data;
            held_last = m_last;
            if (out_fire) begin
                if (sb.size() == 0) begin
                    check("spurious_beat", 64'(m_valid), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check("out_data", 64'(m_data), 64'(e.data));
                    check("out_last", 64'(m_last), 64'(e.last));
                    if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'(S));
                    last_pop = m_data;
                    npop++;
                end
            end
            check("err_flag", 64'(err), 64'(err_exp));
            if (fired) begin
                e.data = ref_calc(da, db, dc, mode);
                e.last = la & lb & lc;
                e.cyc  = cyc;
                sb.push_back(e);
`ifdef DSP_AXIS_LAST_CHECK_EN
                if (!(la == lb && lb == lc)) err_exp = 1'b1;
`endif
            end
        end
        @(posedge clk);
        cyc++;
        if (reset) begin
            sb.delete();
            err_exp = 1'b0;
            held    = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_beat(input logic signed [DW-1:0] a, b, c, input logic [1:0] m,
                            input logic l_a, l_b, l_c);
        da = a; db = b; dc = c; mode = m;
        la = l_a; lb = l_b; lc = l_c;
        va = 1'b1; vb = 1'b1; vc = 1'b1;
    endtask

    task automatic one_beat(input string tag, input logic signed [DW-1:0] a, b, c,
                            input logic [1:0] m, input logic l_a, l_b, l_c, input longint exp);
        int           n0;
        logic [W-1:0] e;
        e       = W'(exp);
        n0      = npop;
        m_ready = 1'b1;
        lat_chk = 1'b1;
        set_beat(a, b, c, m, l_a, l_b, l_c);
        cycle();
        check({tag, "_join"}, 64'(fired), 64'(1));
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        repeat (S + 2) cycle();
        lat_chk = 1'b0;
        check({tag, "_count"}, 64'(npop - n0), 64'(1));
        check(tag, 64'(last_pop), 64'(e));
    endtask

    initial begin
        int n0, sent, t;
        reset = 1'b1; m_ready = 1'b0; mode = 2'd0;
        da = '0; db = '0; dc = '0;
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        la = 1'b0; lb = 1'b0; lc = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 1'b0;
        check("rst_valid", 64'(m_valid), 64'(0));
        check("rst_data", 64'(m_data), 64'(0));
        check("rst_last", 64'(m_last), 64'(0));
        check("rst_err", 64'(err), 64'(0));

        one_beat("m0_basic", 3, 4, 5, 2'd0, 1'b0, 1'b0, 1'b0, 35);
        one_beat("m1_signed", -2, 7, 3, 2'd1, 1'b0, 1'b0, 1'b0, -27);
        one_beat("m2_signed", -2, 7, 3, 2'd2, 1'b0, 1'b0, 1'b0, -11);
        one_beat("m3_signed", -2, 7, 3, 2'd3, 1'b0, 1'b0, 1'b0, -17);
        one_beat("m0_extreme", -32768, -32768, -32768, 2'd0, 1'b0, 1'b0, 1'b0, 64'sd2147483648);
        one_beat("m2_zero", 0, 5, 0, 2'd2, 1'b0, 1'b0, 1'b0, 0);
        one_beat("last_all", 9, 1, 2, 2'd0, 1'b1, 1'b1, 1'b1, 20);

        // Partial valid: nothing consumed until the third stream arrives.
        n0 = npop;
        set_beat(1, 1, 2, 2'd0, 1'b0, 1'b0, 1'b0);
        vc = 1'b0;
        repeat (5) begin
            cycle();
            check("partial_no_join", 64'(fired), 64'(0));
        end
        check("partial_no_out", 64'(npop - n0), 64'(0));
        one_beat("partial_then_c", 1, 1, 2, 2'd0, 1'b0, 1'b0, 1'b0, 4);

        // Ten back-to-back beats with the output stalled for a window.
        n0 = npop; sent = 0; t = 0;
        while (sent < 10 && t < 100) begin
            set_beat(DW'(sent * 7 - 20), DW'(sent + 3), DW'(-sent), 2'(sent), 1'b0, 1'b0, 1'b0);
            m_ready = !(t >= 3 && t <= 8);
            cycle();
            if (fired) sent++;
            t++;
        end
        check("stream_sent", 64'(sent), 64'(10));
        va = 1'b0; vb = 1'b0; vc = 1'b0; m_ready = 1'b1;
        repeat (S + 4) cycle();
        check("stream_delivered", 64'(npop - n0), 64'(10));
        check("stream_drained", 64'(sb.size()), 64'(0));

`ifdef DSP_AXIS_LAST_CHECK_EN
        one_beat("last_mismatch", 2, 2, 2, 2'd2, 1'b1, 1'b0, 1'b1, 6);
        repeat (3) cycle();
        check("err_sticky", 64'(err), 64'(1));
`endif

        // Randomized traffic: streams arrive independently and hold until joined.
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (fired) begin va = 1'b0; vb = 1'b0; vc = 1'b0; end
            if (!va && $urandom_range(0, 3) != 0) begin va = 1'b1; da = DW'($urandom); la = ($urandom_range(0, 3) != 0); end
            if (!vb && $urandom_range(0, 3) != 0) begin vb = 1'b1; db = DW'($urandom); lb = ($urandom_range(0, 3) != 0); end
            if (!vc && $urandom_range(0, 3) != 0) begin vc = 1'b1; dc = DW'($urandom); lc = ($urandom_range(0, 3) != 0); end
            mode    = 2'($urandom);
            m_ready = ($urandom_range(0, 9) < 7);
            cycle();
        end
        va = 1'b0; vb = 1'b0; vc = 1'b0; m_ready = 1'b1;
        repeat (S + 4) cycle();
        check("random_drained", 64'(sb.size()), 64'(0));

        // Reset with beats in flight: they must never appear.
        m_ready = 1'b0;
        set_beat(11, 12, 13, 2'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        set_beat(21, 22, 23, 2'd1, 1'b0, 1'b0, 1'b0);
        cycle();
        va = 1'b0; vb = 1'b0; vc = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("midrst_valid", 64'(m_valid), 64'(0));
        check("midrst_data", 64'(m_data), 64'(0));
        check("midrst_err", 64'(err), 64'(0));
        n0 = npop;
        m_ready = 1'b1;
        repeat (S + 4) begin
            cycle();
            check("midrst_quiet", 64'(m_valid), 64'(0));
        end
        check("midrst_no_pop", 64'(npop - n0), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
